joy_dir_filter: RTL and testbench
=================================

# joy_dir_filter

Parametrised per-player digital joystick conditioner that sits between the merged keyboard/USB/DB9/DB15 direction bits and a core's switch-register inputs. It generalises the two-way left/right arbiter to N players and four directions. It adds a two-flop synchroniser, a per-player debouncer, a selectable 8-way/4-way/2-way restriction, and a selectable opposing-direction (SOCD) policy. Output is registered per player, with a one-cycle change strobe for cores that latch inputs on events.

## Interface
- NPLAYERS, 2: number of independent player channels.
- DEB_W, 16: debounce counter width.
- DEB_CYCLES, 48000: clocks an input vector must stay unchanged before acceptance (1 ms at 48 MHz). 0 bypasses debounce. Must be < 2^DEB_W.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 = 8-way, 1 = 4-way, 2 = 2-way horizontal, 3 = 2-way vertical; shared by all players.
- socd  in  1  0 = last-pressed wins, 1 = opposing pair resolves to neutral.
- joy_in  in  4*NPLAYERS  raw active-high {U,D,L,R} per player; player p at [4p+3:4p]; may be asynchronous.
- joy_out  out  4*NPLAYERS  filtered {U,D,L,R}, same packing.
- changed  out  NPLAYERS  one-cycle pulse when that player's joy_out changes.

## Operation
- **Sync:** per player, a 2-flop synchroniser on all 4 bits.
- **Debounce (per player):**
  - If the synced vector ≠ cand: cand ← synced, cnt ← 0.
  - Otherwise cnt increments, saturating at DEB_CYCLES.
  - stable ← cand on the cycle cnt == DEB_CYCLES.
  - Any mid-count change restarts the count; glitches shorter than DEB_CYCLES never reach stable.
- **Edge detect:** new = stable & ~stable_q, where stable_q is stable delayed one clock.
- **Axis resolve, horizontal (vertical is identical with U/D):**
  - new R sets last_h = R. new L sets last_h = L.
  - Both new in the same cycle: L wins (U wins on the vertical axis).
  - Both held: output last_h if socd = 0, neutral if socd = 1.
  - One held: that one. None held: neutral.
- **Mode restrict**, applied after axis resolve:
  - 8-way: both axes pass.
  - 4-way:
    - last_axis ← H when the resolved horizontal goes neutral→active; ← V likewise for vertical.
    - Both go active in the same cycle: H wins.
    - When both axes are active, only last_axis passes. One active axis always passes.
  - 2-way H/V: the other axis is forced to 0.
- **Output:** joy_out is registered. changed[p] = 1 for one cycle when the new joy_out[p] ≠ the previous one.
- **Live controls:** mode and socd changes take effect on the next resolve cycle. Memory registers are not cleared, and the resulting output change pulses changed.
- **Reset:** asynchronous, clears synchronisers, cand, cnt (0), stable, stable_q, last_h, last_v, last_axis (H), joy_out (0) and changed (0). Reset asserted mid-debounce discards the pending vector.

## Timing
- Latency from the first clk_sys edge seeing a new, held joy_in: DEB_CYCLES + 4 clocks to joy_out. With DEB_CYCLES = 0: 3 clocks.
- changed pulses on the same cycle joy_out updates.
- The pipeline sustains one new accepted vector per clock per player; players are fully independent.
- No handshake. Outputs are level, except the changed strobe.

## Structure
- Package joy_pkg holds:
  - mode localparams (JOY_8WAY = 0, JOY_4WAY = 1, JOY_2WAY_H = 2, JOY_2WAY_V = 3);
  - bit indices (JR = 0, JL = 1, JD = 2, JU = 3);
  - the axis enum (AX_H, AX_V).
- Sub-module joy_debounce (sync + cand/cnt/stable, params DEB_W, DEB_CYCLES) is instantiated NPLAYERS times by a generate loop. Resolve and restrict logic stays in the top.

## Test plan
- **Basic path:** DEB_CYCLES = 4, mode 0; set joy_in[0] = R, hold → joy_out[3:0] = 4'b0001 exactly 8 clocks later; changed[0] pulses once.
- **Glitch:** DEB_CYCLES = 4; 3-cycle pulse on L → joy_out stays 0, changed never asserts.
- **SOCD last-wins:** mode 0, socd 0; hold R, then add L → output L (4'b0010); release L → R. Repeat with socd 1 → both held gives 4'b0000.
- **4-way:** mode 1; hold U (4'b1000), then add R → 4'b0001; release R → 4'b1000. U and R arriving together → R.
- **2-way V + player independence:** mode 3, NPLAYERS 2; player 1 holds U+R → joy_out[7:4] = 4'b1000, while player 0 activity leaves changed[1] untouched.
- **Reset mid-debounce:** assert reset_n = 0 at cnt = 2 with joy_in = D held → all outputs 0 immediately. After release, D appears after a full DEB_CYCLES + 4 clocks.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared constants and helpers for the joystick direction conditioner.
package joy_pkg;

  localparam logic [1:0] JOY_8WAY   = 2'd0;
  localparam logic [1:0] JOY_4WAY   = 2'd1;
  localparam logic [1:0] JOY_2WAY_H = 2'd2;
  localparam logic [1:0] JOY_2WAY_V = 2'd3;

  // Bit positions inside a player's {U,D,L,R} nibble
  localparam int unsigned JR = 0;
  localparam int unsigned JL = 1;
  localparam int unsigned JD = 2;
  localparam int unsigned JU = 3;

  typedef enum logic {AX_H = 1'b0, AX_V = 1'b1} axis_e;

  // Axis pairs are packed {hi,lo} = {L,R} or {U,D}; hi wins a same-cycle tie.
  // Returns the updated "last pressed" side (1 = hi, 0 = lo).
  function automatic logic pair_last(input logic [1:0] is_new, input logic last_q);
    if (is_new[1]) return 1'b1;
    if (is_new[0]) return 1'b0;
    return last_q;
  endfunction

  // Resolves one opposing pair under the selected SOCD policy.
  function automatic logic [1:0] pair_out(input logic [1:0] held, input logic last_hi,
                                          input logic socd);
    if (held == 2'b11) begin
      if (socd) return 2'b00;
      return last_hi ? 2'b10 : 2'b01;
    end
    return held;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-player two-flop synchroniser followed by a restart-on-change debouncer.
module joy_debounce #(
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned DEB_CYCLES = 48000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] raw_i,
  output logic [3:0] stable_o
);

  logic [3:0] sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous direction bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  if (DEB_CYCLES == 0) begin : g_bypass
    assign stable_o = sync2_q;
  end else begin : g_deb
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

    logic [3:0]       cand_q, cand_d, stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // Restart on any change; accept the candidate as the count reaches DEB_MAX
    always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (cnt_q != DEB_MAX) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == DEB_MAX) stable_d = cand_q;
      end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cand_q   <= '0;
        cnt_q    <= '0;
        stable_q <= '0;
      end else begin
        cand_q   <= cand_d;
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_o = stable_q;
  end

endmodule

// File: rtl/joy_dir_filter.sv
// N-player joystick conditioner: debounce, SOCD resolve, way restriction, change strobe.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int unsigned NPLAYERS   = 2,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned DEB_CYCLES = 48000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  socd,
  input  logic [4*NPLAYERS-1:0] joy_in,
  output logic [4*NPLAYERS-1:0] joy_out,
  output logic [NPLAYERS-1:0]   changed
);

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic [3:0] stable, stable_q, new_v, out_d, out_q;
    logic       last_h_q, last_h_d, last_v_q, last_v_d;
    logic       h_act, v_act, h_act_q, v_act_q, chg_q;
    logic [1:0] h_res, v_res;
    axis_e      last_axis_q, last_axis_d;

    joy_debounce #(
      .DEB_W      (DEB_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk_i    (clk_sys),
      .rst_ni   (reset_n),
      .raw_i    (joy_in[4*p +: 4]),
      .stable_o (stable)
    );

    // Resolve each axis, then apply the way restriction
    always_comb begin
      new_v       = stable & ~stable_q;
      last_h_d    = pair_last({new_v[JL], new_v[JR]}, last_h_q);
      last_v_d    = pair_last({new_v[JU], new_v[JD]}, last_v_q);
      h_res       = pair_out({stable[JL], stable[JR]}, last_h_d, socd);
      v_res       = pair_out({stable[JU], stable[JD]}, last_v_d, socd);
      h_act       = |h_res;
      v_act       = |v_res;
      last_axis_d = last_axis_q;
      if (h_act && !h_act_q)      last_axis_d = AX_H;
      else if (v_act && !v_act_q) last_axis_d = AX_V;
      out_d = {v_res, h_res};
      case (mode)
        JOY_8WAY:   out_d = {v_res, h_res};
        JOY_4WAY: begin
          if (h_act && v_act)
            out_d = (last_axis_d == AX_H) ? {2'b00, h_res} : {v_res, 2'b00};
        end
        JOY_2WAY_H: out_d = {2'b00, h_res};
        default:    out_d = {v_res, 2'b00};
      endcase
    end

    // Per-player memory, registered output and change strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        stable_q    <= '0;
        last_h_q    <= 1'b0;
        last_v_q    <= 1'b0;
        h_act_q     <= 1'b0;
        v_act_q     <= 1'b0;
        last_axis_q <= AX_H;
        out_q       <= '0;
        chg_q       <= 1'b0;
      end else begin
        stable_q    <= stable;
        last_h_q    <= last_h_d;
        last_v_q    <= last_v_d;
        h_act_q     <= h_act;
        v_act_q     <= v_act;
        last_axis_q <= last_axis_d;
        out_q       <= out_d;
        chg_q       <= (out_d != out_q);
      end
    end

    assign joy_out[4*p +: 4] = out_q;
    assign changed[p]        = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: latency, glitch, reset and a table of steady-state vectors.
module tb_joy_dir_filter;
  import joy_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic       socd;
  logic [7:0] joy_in, joy_out;
  logic [1:0] changed;
  logic [3:0] joy_in0, joy_out0;
  logic [0:0] changed0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk_sys = ~clk_sys;

  joy_dir_filter #(.NPLAYERS(2), .DEB_W(8), .DEB_CYCLES(4)) dut (
    .clk_sys (clk_sys), .reset_n (reset_n), .mode (mode), .socd (socd),
    .joy_in (joy_in), .joy_out (joy_out), .changed (changed)
  );

  joy_dir_filter #(.NPLAYERS(1), .DEB_W(4), .DEB_CYCLES(0)) dut0 (
    .clk_sys (clk_sys), .reset_n (reset_n), .mode (mode), .socd (socd),
    .joy_in (joy_in0), .joy_out (joy_out0), .changed (changed0)
  );

  typedef struct {
    string       name;
    logic [7:0]  joy;
    logic [1:0]  mode;
    logic        socd;
    logic [7:0]  exp_out;
    int unsigned exp_c0;
    int unsigned exp_c1;
  } vec_t;

  vec_t vecs[21];
  vec_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [7:0] j, input logic [1:0] m,
                              input logic s, input logic [7:0] e, input int unsigned c0,
                              input int unsigned c1);
    vec_t v;
    v.name = n; v.joy = j; v.mode = m; v.socd = s;
    v.exp_out = e; v.exp_c0 = c0; v.exp_c1 = c1;
    return v;
  endfunction

  // Counts clocks from the drive edge; out must switch exactly on clock 8 (DEB_CYCLES + 4)
  task automatic latency_run(input string tag, input logic [7:0] exp_val);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_sys);
      check({tag, "_out"}, 32'(joy_out), (k >= 8) ? 32'(exp_val) : 32'd0);
      check({tag, "_chg"}, 32'(changed[0]), (k == 8) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    vec_t        v, e;
    int unsigned c0, c1;
    logic        bad_out, bad_chg;

    vecs[0]  = mk("r_only",      8'h01, JOY_8WAY,   1'b0, 8'h01, 1, 0);
    vecs[1]  = mk("r_then_l",    8'h03, JOY_8WAY,   1'b0, 8'h02, 1, 0);
    vecs[2]  = mk("rel_l",       8'h01, JOY_8WAY,   1'b0, 8'h01, 1, 0);
    vecs[3]  = mk("socd_both",   8'h03, JOY_8WAY,   1'b1, 8'h00, 1, 0);
    vecs[4]  = mk("socd_rel_l",  8'h01, JOY_8WAY,   1'b1, 8'h01, 1, 0);
    vecs[5]  = mk("idle_a",      8'h00, JOY_8WAY,   1'b1, 8'h00, 1, 0);
    vecs[6]  = mk("u_4way",      8'h08, JOY_4WAY,   1'b0, 8'h08, 1, 0);
    vecs[7]  = mk("add_r_4way",  8'h09, JOY_4WAY,   1'b0, 8'h01, 1, 0);
    vecs[8]  = mk("rel_r_4way",  8'h08, JOY_4WAY,   1'b0, 8'h08, 1, 0);
    vecs[9]  = mk("idle_b",      8'h00, JOY_4WAY,   1'b0, 8'h00, 1, 0);
    vecs[10] = mk("ur_together", 8'h09, JOY_4WAY,   1'b0, 8'h01, 1, 0);
    vecs[11] = mk("idle_c",      8'h00, JOY_4WAY,   1'b0, 8'h00, 1, 0);
    vecs[12] = mk("p1_ur_2v",    8'h90, JOY_2WAY_V, 1'b0, 8'h80, 0, 1);
    vecs[13] = mk("p0_u_2v",     8'h98, JOY_2WAY_V, 1'b0, 8'h88, 1, 0);
    vecs[14] = mk("to_2h",       8'h98, JOY_2WAY_H, 1'b0, 8'h10, 1, 1);
    vecs[15] = mk("to_8way",     8'h98, JOY_8WAY,   1'b0, 8'h98, 1, 1);
    vecs[16] = mk("idle_d",      8'h00, JOY_8WAY,   1'b0, 8'h00, 1, 1);
    vecs[17] = mk("d_only",      8'h04, JOY_8WAY,   1'b0, 8'h04, 1, 0);
    vecs[18] = mk("d_then_u",    8'h0C, JOY_8WAY,   1'b0, 8'h08, 1, 0);
    vecs[19] = mk("rel_u",       8'h04, JOY_8WAY,   1'b0, 8'h04, 1, 0);
    vecs[20] = mk("idle_e",      8'h00, JOY_8WAY,   1'b0, 8'h00, 1, 0);

    reset_n = 1'b0; mode = JOY_8WAY; socd = 1'b0; joy_in = '0; joy_in0 = '0;
    #12;
    check("reset_out", 32'(joy_out), 32'd0);
    check("reset_chg", 32'(changed), 32'd0);
    check("reset_out0", 32'(joy_out0), 32'd0);
    @(negedge clk_sys); reset_n = 1'b1;
    repeat (8) @(negedge clk_sys);

    // Basic path, plus the bypassed debouncer seeing the same press
    joy_in = 8'h01; joy_in0 = 4'h1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_sys);
      check("basic_out", 32'(joy_out), (k >= 8) ? 32'h01 : 32'd0);
      check("basic_chg", 32'(changed[0]), (k == 8) ? 32'd1 : 32'd0);
      check("bypass_out", 32'(joy_out0), (k >= 3) ? 32'h1 : 32'd0);
      check("bypass_chg", 32'(changed0), (k == 3) ? 32'd1 : 32'd0);
    end
    joy_in = '0; joy_in0 = '0;
    repeat (12) @(negedge clk_sys);

    // Short glitch on L must be filtered out completely
    joy_in = 8'h02;
    repeat (3) @(negedge clk_sys);
    joy_in = '0;
    bad_out = 1'b0; bad_chg = 1'b0;
    repeat (15) begin
      @(negedge clk_sys);
      if (joy_out != 8'h00) bad_out = 1'b1;
      if (changed != 2'b00) bad_chg = 1'b1;
    end
    check("glitch_out", 32'(bad_out), 32'd0);
    check("glitch_chg", 32'(bad_chg), 32'd0);

    // Table: drive, push expectation, settle while counting strobes, pop and compare
    foreach (vecs[i]) begin
      v = vecs[i];
      joy_in = v.joy; mode = v.mode; socd = v.socd;
      sbq.push_back(v);
      c0 = 0; c1 = 0;
      repeat (12) begin
        @(negedge clk_sys);
        c0 += 32'(changed[0]);
        c1 += 32'(changed[1]);
      end
      e = sbq.pop_front();
      check({e.name, "_out"}, 32'(joy_out), 32'(e.exp_out));
      check({e.name, "_chg0"}, c0, e.exp_c0);
      check({e.name, "_chg1"}, c1, e.exp_c1);
    end

    // Reset mid-debounce: R established, D pending at cnt = 2 when reset hits
    mode = JOY_8WAY; socd = 1'b0; joy_in = 8'h01;
    repeat (12) @(negedge clk_sys);
    check("pre_reset_out", 32'(joy_out), 32'h01);
    joy_in = 8'h04;
    repeat (5) @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out", 32'(joy_out), 32'd0);
    check("midrst_chg", 32'(changed), 32'd0);
    @(negedge clk_sys); reset_n = 1'b1;
    latency_run("after_rst", 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
